rr_arbiter4: RTL and testbench

//   Round-robin arbiter sharing one 4:1-muxed resource among 4 requesters.

---
 rtl/rr_arbiter4.sv | 140 ++++++++++++++
 tb/tb_rr_arbiter4.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-way round-robin arbiter for a shared 4:1-muxed resource.
// Registers a one-hot grant plus the matching 2-bit mux select.
// Optional feature macro: RR_ARB_HOLD_LIMIT_EN (caps ownership at HOLD_MAX
// consecutive cycles when another requester is waiting).
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset
//   req   - level requests, bit i = requester i
//   grant - registered one-hot grant, 0000 when idle
//   sel   - index of current/last owner (drives shared mux select)
//   busy  - 1 while any grant is held
module rr_arbiter4 #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy
);

    typedef enum logic {
        S_IDLE,
        S_OWN
    } state_t;

    state_t     r_state;
    logic [3:0] r_grant;
    logic [1:0] r_sel;
    logic       r_busy;
    logic [1:0] r_ptr;

    logic       w_owner_req;
    logic       w_others;
    logic       w_handover;
    logic [1:0] w_base;
    logic [1:0] w_win;
    logic [3:0] w_win_oh;

    if (HOLD_MAX < 2) begin : g_bad_hold_max
        $error("rr_arbiter4: HOLD_MAX must be >= 2");
    end

    // First set request scanning upward from base+1; base itself is
    // visited last, so a just-released owner has lowest priority.
    function automatic logic [1:0] f_pick(input logic [3:0] rq,
                                          input logic [1:0] base);
        logic [1:0] idx;
        f_pick = base;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (rq[idx]) f_pick = idx;
        end
    endfunction

    assign w_owner_req = |(req & r_grant);
    assign w_others    = |(req & ~r_grant);
    // While idle scan from the pointer; on handover from the owner.
    assign w_base      = (r_state == S_OWN) ? r_sel : r_ptr;
    assign w_win       = f_pick(req, w_base);
    assign w_win_oh    = 4'b0001 << w_win;

`ifdef RR_ARB_HOLD_LIMIT_EN
    localparam int CW = $clog2(HOLD_MAX);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

    logic [CW-1:0] r_hold_cnt;
    logic          w_hold_top;
    logic          w_preempt;

    assign w_hold_top = (r_hold_cnt == HOLD_LAST);
    assign w_preempt  = (r_state == S_OWN) && w_owner_req &&
                        w_hold_top && w_others;
    assign w_handover = ((r_state == S_OWN) && !w_owner_req) || w_preempt;
`else
    logic w_unused;

    assign w_unused   = w_others;
    assign w_handover = (r_state == S_OWN) && !w_owner_req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= 4'b0000;
            r_sel   <= 2'b00;
            r_busy  <= 1'b0;
            r_ptr   <= 2'd3;
`ifdef RR_ARB_HOLD_LIMIT_EN
            r_hold_cnt <= '0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_state <= S_OWN;
                        r_grant <= w_win_oh;
                        r_sel   <= w_win;
                        r_busy  <= 1'b1;
                    end
`ifdef RR_ARB_HOLD_LIMIT_EN
                    r_hold_cnt <= '0;
`endif
                end
                S_OWN: begin
                    if (w_handover) begin
                        r_ptr <= r_sel;
                        if (|req) begin
                            r_grant <= w_win_oh;
                            r_sel   <= w_win;
                        end else begin
                            // sel keeps the last owner while idle
                            r_state <= S_IDLE;
                            r_grant <= 4'b0000;
                            r_busy  <= 1'b0;
                        end
                    end
`ifdef RR_ARB_HOLD_LIMIT_EN
                    // Limit reached with nobody waiting: restart the window.
                    if (w_handover || w_hold_top)
                        r_hold_cnt <= '0;
                    else
                        r_hold_cnt <= r_hold_cnt + 1'b1;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 4'b0000;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign sel   = r_sel;
    assign busy  = r_busy;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: self-checking bench for rr_arbiter4.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_rr_arbiter4;

    localparam int HM = 4;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: owner index (-1 = nobody), pointer, select, hold.
    int m_owner;
    int m_ptr;
    int m_sel;
    int m_hold;

    rr_arbiter4 #(.HOLD_MAX(HM)) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .grant(grant),
        .sel  (sel),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got,
                         input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic int scan(input logic [3:0] r, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_grant();
        return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 3;
        m_sel   = 0;
        m_hold  = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        if (m_owner < 0) begin
            if (r != 0) m_owner = scan(r, m_ptr);
            m_hold = 0;
        end else if (!r[m_owner]) begin
            m_ptr   = m_owner;
            m_owner = (r != 0) ? scan(r, m_owner) : -1;
            m_hold  = 0;
        end else begin
`ifdef RR_ARB_HOLD_LIMIT_EN
            if (m_hold == HM - 1) begin
                if ((r & ~(4'(1 << m_owner))) != 0) begin
                    m_ptr   = m_owner;
                    m_owner = scan(r, m_owner);
                end
                m_hold = 0;
            end else begin
                m_hold++;
            end
`endif
        end
        if (m_owner >= 0) m_sel = m_owner;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".grant"}, grant, m_grant());
        check({tag, ".sel"}, {2'b00, sel}, 4'(m_sel));
        check({tag, ".busy"}, {3'b000, busy}, {3'b000, m_owner >= 0});
        check({tag, ".onehot"}, {3'b000, $onehot0(grant)}, 4'b0001);
    endtask

    // Starts and ends on a falling edge.
    task automatic cycle(input logic [3:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
        check_all(tag);
    endtask

    // Async reset raised mid-cycle; outputs must drop before any clock edge.
    task automatic do_reset(input logic [3:0] r);
        req = r;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [3:0] g_seq [4];
    logic [3:0] seq4  [12];

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        model_reset();

        // 1: reset with all requests; first grant goes to requester 0
        @(negedge clk);
        req = 4'b1111;
        #1;
        check_all("t1_rst");
        @(negedge clk);
        reset = 1'b0;
        cycle(4'b1111, "t1_first");
        check("t1_g", grant, 4'b0001);

        // 2: each owner releases for one cycle after two grant cycles
        g_seq[0] = 4'b0010;
        g_seq[1] = 4'b0100;
        g_seq[2] = 4'b1000;
        g_seq[3] = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            cycle(4'b1111, "t2_hold");
            cycle(4'b1111 & ~grant, "t2_drop");
            check("t2_seq", grant, g_seq[i]);
            check("t2_busy", {3'b000, busy}, 4'b0001);
        end

        // 3: single requester then idle; sel keeps last owner
        do_reset(4'b0000);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0100, "t3_own");
            check("t3_g", grant, 4'b0100);
        end
        cycle(4'b0000, "t3_idle");
        check("t3_gi", grant, 4'b0000);
        check("t3_sel", {2'b00, sel}, 4'b0010);
        cycle(4'b0000, "t3_idle2");
        check("t3_sel2", {2'b00, sel}, 4'b0010);

        // 5: owner 1 releases as 3 and 0 arrive -> rotation picks 3
        do_reset(4'b0000);
        cycle(4'b0010, "t5_own");
        check("t5_g1", grant, 4'b0010);
        cycle(4'b1001, "t5_hand");
        check("t5_g", grant, 4'b1000);
        check("t5_sel", {2'b00, sel}, 4'b0011);

        // 4: constant 0011, hold limit behaviour depends on build
        do_reset(4'b0000);
        for (int i = 0; i < 12; i++) begin
`ifdef RR_ARB_HOLD_LIMIT_EN
            seq4[i] = (i >= 4 && i < 8) ? 4'b0010 : 4'b0001;
`else
            seq4[i] = 4'b0001;
`endif
        end
        for (int i = 0; i < 12; i++) begin
            cycle(4'b0011, "t4");
            check("t4_seq", grant, seq4[i]);
        end

        // 6: reset while grant=0100, then restart with req=1000
        do_reset(4'b0000);
        cycle(4'b0100, "t6_own");
        check("t6_g", grant, 4'b0100);
        do_reset(4'b0100);
        check("t6_rst", grant, 4'b0000);
        cycle(4'b1000, "t6_after");
        check("t6_g2", grant, 4'b1000);

        // Random traffic: requests tend to persist, occasional resets
        for (int i = 0; i < 600; i++) begin
            logic [3:0] r;
            r = req;
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            if (m_owner >= 0 && $urandom_range(0, 5) == 0)
                r[m_owner] = 1'b0;
            if ($urandom_range(0, 79) == 0)
                do_reset(r);
            cycle(r, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
